usb_rx_decoder: RTL and testbench
=================================

# usb_rx_decoder

Receive-side bit-level decoder for the USB 2.0 high-speed PHY, directly downstream of the data-recovery stage (`dr_toplevel`). It takes the recovered 480 Mb/s serial bit stream and performs NRZI decoding, SYNC detection and bit unstuffing. It assembles bytes LSB-first, detects the HS end-of-packet (bit-stuff violation), and presents bytes to the link layer with a valid strobe and packet framing flags.

## Interface
Parameters:
- `SYNC_MIN_ZEROS`, 12, minimum decoded-zero run that must precede the SYNC-terminating 1 (range 2..31).
- `IDLE_TIMEOUT`, 16, maximum consecutive cycles with `bit_valid` low inside a packet before abort (range 2..255).

Ports:
- `clock_480`  in  1  480 MHz receive clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `bit_in`  in  1  recovered line bit (NRZI-encoded), from `dr_toplevel.data_out`.
- `bit_valid`  in  1  `bit_in` carries a new bit this cycle. This is low during recovery slip.
- `rx_active`  out  1  high from SYNC detection until the packet ends.
- `rx_data`  out  8  assembled byte, LSB = first received bit.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` is a new byte.
- `rx_eop`  out  1  one-cycle strobe: packet terminated.
- `rx_error`  out  1  one-cycle strobe, coincident with `rx_eop`: termination was abnormal.

## Operation
NRZI decode:
- `line_prev` is updated only on `bit_valid`.
- Decoded bit `d` = 1 if `bit_in == line_prev`, else 0.

State machine, states HUNT / DATA. Bits are processed only on `bit_valid` cycles.
- **HUNT**: `zero_cnt` counts consecutive `d`=0 and saturates at 31.
  - `d`=1 with `zero_cnt >= SYNC_MIN_ZEROS` → DATA. Set `rx_active`=1, `bit_cnt`=0, `ones_cnt`=1 (the SYNC 1 counts toward stuffing). Clear `zero_cnt`.
  - `d`=1 with a shorter run → clear `zero_cnt` and stay in HUNT.
- **DATA**:
  - `ones_cnt`==6 and `d`=0: stuffed bit. Discard it, `ones_cnt`=0, `bit_cnt` unchanged.
  - `ones_cnt`==6 and `d`=1: EOP. Pulse `rx_eop`. Pulse `rx_error` unless `bit_cnt`==7 (a clean HS EOP byte 0xFE leaves its leading 0 and six 1s pending). Discard the partial byte, drop `rx_active`, go to HUNT.
  - Otherwise: shift `d` into bit position `bit_cnt`. `ones_cnt` becomes `ones_cnt`+1 if `d`=1, else 0. On `bit_cnt`==7, load `rx_data`, pulse `rx_valid`, and wrap `bit_cnt` to 0.
  - Timeout: `gap_cnt` counts consecutive `bit_valid`=0 cycles and clears on any valid bit. Reaching `IDLE_TIMEOUT` forces `rx_eop`=1 and `rx_error`=1, drops `rx_active`, discards the partial byte, and returns to HUNT.
- `rx_valid` and `rx_eop` never assert in the same cycle. A byte completes only on a data bit, and EOP only on a violating bit.

## Timing
- Reset values:
  - All outputs 0. `rx_data` = 8'h00.
  - State HUNT. All counters 0. `line_prev` = 0.
- All outputs are registered.
- Latency:
  - `rx_valid` asserts the cycle after the clock edge that samples the byte's 8th data bit.
  - `rx_active` rises the cycle after the SYNC-terminating bit is sampled.
  - `rx_eop`, `rx_error` and the falling `rx_active` appear in the same cycle, one cycle after the violating bit (or the timeout cycle) is sampled.
- `rx_data` holds its value until the next byte.
- Throughput: one byte per 8 data bits. Back-to-back bytes give `rx_valid` pulses 8 valid cycles apart, or 9 when a stuffed bit intervenes.
- Reset asserted mid-packet: all state clears immediately. No `rx_eop` is emitted.
- Decoding in HUNT resumes on the first valid bit after an EOP.

## Configuration
- `USB_RX_BYTE_COUNT_EN`:
  - Defined: adds output port `rx_byte_count` (11 bits).
    - Cleared to 0 on SYNC detection.
    - Incremented with each `rx_valid`, saturating at 2047.
    - Held after EOP until the next SYNC.
    - Reset value 0.
  - Undefined: port and counter are absent. All other behaviour is identical.

## Test plan
- Reset/idle: hold `reset_n`=0, then drive 40 valid bits with no transitions → all outputs stay 0 and `rx_active` never rises. (Decoded stream is all 1s; there is no zero run.)
- Nominal packet: 31 decoded 0s + 1, then bytes 0xA5, 0x3C, then the 0xFE EOP pattern → `rx_valid` pulses with `rx_data`=0xA5 then 0x3C. Then `rx_eop`=1, `rx_error`=0, `rx_active` falls.
- Stuffing: SYNC, then byte 0xFF followed by 0x01, with a stuffed 0 inserted after each run of six 1s → outputs exactly 0xFF, 0x01. No error, and stuffed bits do not shift `bit_cnt`.
- Short SYNC: 8 decoded 0s then 1 with `SYNC_MIN_ZEROS`=12 → stays in HUNT. A following 12-zero + 1 sequence then enters DATA.
- Bad EOP and gaps:
  - Seven consecutive 1s arriving with `bit_cnt`=3 → `rx_eop`=1 and `rx_error`=1 in the same cycle, and no `rx_valid` for the partial byte.
  - Inserting one `bit_valid`=0 cycle mid-byte does not alter the decoded data.
- Timeout: after SYNC and 4 data bits, hold `bit_valid`=0 for 16 cycles → `rx_eop`=`rx_error`=1 exactly once, and `rx_active` falls. With `USB_RX_BYTE_COUNT_EN`, `rx_byte_count`=0 here and 2 in the nominal packet.

Source files
------------

// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder: receive-side bit decoder for a USB 2.0 HS PHY.
// NRZI-decodes the recovered bit stream, detects SYNC, removes stuffed bits,
// assembles bytes LSB-first and frames packets. The HS EOP is detected as a
// bit-stuff violation. A packet is also aborted on a long bit_valid gap.
//
// Ports:
//   clock_480     - 480 MHz receive clock
//   reset_n       - asynchronous active-low reset
//   bit_in        - recovered NRZI line bit
//   bit_valid     - bit_in carries a new bit this cycle
//   rx_active     - high from SYNC detection until the packet ends
//   rx_data       - last assembled byte (bit 0 = first bit received)
//   rx_valid      - one-cycle strobe: rx_data holds a new byte
//   rx_eop        - one-cycle strobe: the packet has terminated
//   rx_error      - one-cycle strobe with rx_eop: abnormal termination
//   rx_byte_count - bytes in the current/last packet, saturating at 2047
//                   (present only when USB_RX_BYTE_COUNT_EN is defined)
//
// Optional feature macro: USB_RX_BYTE_COUNT_EN.
module usb_rx_decoder #(
    parameter int unsigned SYNC_MIN_ZEROS = 12,
    parameter int unsigned IDLE_TIMEOUT   = 16
) (
    input  logic        clock_480,
    input  logic        reset_n,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic        rx_active,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_eop,
    output logic        rx_error
`ifdef USB_RX_BYTE_COUNT_EN
    ,
    output logic [10:0] rx_byte_count
`endif
);

    typedef enum logic [0:0] {StHunt, StData} state_e;

    state_e      state_q, state_d;
    logic        line_prev_q, line_prev_d;
    logic [4:0]  zero_cnt_q, zero_cnt_d;
    logic [2:0]  ones_cnt_q, ones_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic        rx_active_q, rx_active_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_eop_q, rx_eop_d;
    logic        rx_error_q, rx_error_d;

    logic dec_bit;
    logic sync_hit, stuff_bit, eop_hit, data_bit, timeout;

    // NRZI: no transition decodes as 1.
    assign dec_bit = (bit_in == line_prev_q);

    // State register.
    always_ff @(posedge clock_480 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StHunt;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle event decode.
    always_comb begin
        state_d   = state_q;
        sync_hit  = 1'b0;
        stuff_bit = 1'b0;
        eop_hit   = 1'b0;
        data_bit  = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            StHunt: begin
                if (bit_valid && dec_bit && (32'(zero_cnt_q) >= SYNC_MIN_ZEROS)) begin
                    sync_hit = 1'b1;
                    state_d  = StData;
                end
            end
            StData: begin
                if (bit_valid) begin
                    if (ones_cnt_q == 3'd6) begin
                        // Seventh 1 in a row is illegal: that is the HS EOP.
                        if (dec_bit) begin
                            eop_hit = 1'b1;
                            state_d = StHunt;
                        end else begin
                            stuff_bit = 1'b1;
                        end
                    end else begin
                        data_bit = 1'b1;
                    end
                end else if (32'(gap_cnt_q) + 32'd1 >= IDLE_TIMEOUT) begin
                    timeout = 1'b1;
                    state_d = StHunt;
                end
            end
            default: state_d = StHunt;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        line_prev_d = bit_valid ? bit_in : line_prev_q;
        zero_cnt_d  = zero_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        shift_d     = shift_q;
        rx_active_d = rx_active_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_eop_d    = 1'b0;
        rx_error_d  = 1'b0;

        if (state_q == StHunt) begin
            if (bit_valid) begin
                if (dec_bit) begin
                    zero_cnt_d = 5'd0;
                end else if (zero_cnt_q != 5'd31) begin
                    zero_cnt_d = zero_cnt_q + 5'd1;
                end
            end
            if (sync_hit) begin
                rx_active_d = 1'b1;
                bit_cnt_d   = 3'd0;
                ones_cnt_d  = 3'd1;  // the SYNC-terminating 1 counts toward stuffing
                gap_cnt_d   = 8'd0;
            end
        end else begin
            gap_cnt_d = bit_valid ? 8'd0 : gap_cnt_q + 8'd1;
            if (stuff_bit) begin
                ones_cnt_d = 3'd0;
            end
            if (data_bit) begin
                // Shift right so the first bit ends up at bit 0.
                shift_d    = {dec_bit, shift_q[6:1]};
                ones_cnt_d = dec_bit ? ones_cnt_q + 3'd1 : 3'd0;
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    rx_data_d  = {dec_bit, shift_q};
                    rx_valid_d = 1'b1;
                end
            end
            if (eop_hit || timeout) begin
                rx_eop_d    = 1'b1;
                // A clean EOP byte (0xFE) leaves exactly 7 bits pending.
                rx_error_d  = timeout || (bit_cnt_q != 3'd7);
                rx_active_d = 1'b0;
                bit_cnt_d   = 3'd0;
                ones_cnt_d  = 3'd0;
                gap_cnt_d   = 8'd0;
            end
        end
    end

    always_ff @(posedge clock_480 or negedge reset_n) begin
        if (!reset_n) begin
            line_prev_q <= 1'b0;
            zero_cnt_q  <= 5'd0;
            ones_cnt_q  <= 3'd0;
            bit_cnt_q   <= 3'd0;
            gap_cnt_q   <= 8'd0;
            shift_q     <= 7'd0;
            rx_active_q <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_eop_q    <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            line_prev_q <= line_prev_d;
            zero_cnt_q  <= zero_cnt_d;
            ones_cnt_q  <= ones_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            shift_q     <= shift_d;
            rx_active_q <= rx_active_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_eop_q    <= rx_eop_d;
            rx_error_q  <= rx_error_d;
        end
    end

    assign rx_active = rx_active_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_eop    = rx_eop_q;
    assign rx_error  = rx_error_q;

`ifdef USB_RX_BYTE_COUNT_EN
    logic [10:0] byte_cnt_q, byte_cnt_d;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (sync_hit) begin
            byte_cnt_d = 11'd0;
        end else if (rx_valid_d && (byte_cnt_q != 11'h7FF)) begin
            byte_cnt_d = byte_cnt_q + 11'd1;
        end
    end

    always_ff @(posedge clock_480 or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_q <= 11'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign rx_byte_count = byte_cnt_q;
`endif

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed self-checking bench for usb_rx_decoder (default parameters).
module tb_usb_rx_decoder;

    logic       clock_480 = 1'b0;
    logic       reset_n   = 1'b0;
    logic       bit_in    = 1'b0;
    logic       bit_valid = 1'b0;
    logic       rx_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_eop;
    logic       rx_error;
`ifdef USB_RX_BYTE_COUNT_EN
    logic [10:0] rx_byte_count;
    logic [10:0] eop_byte_count;
`endif

    usb_rx_decoder dut (
        .clock_480 (clock_480),
        .reset_n   (reset_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .rx_active (rx_active),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_eop    (rx_eop),
        .rx_error  (rx_error)
`ifdef USB_RX_BYTE_COUNT_EN
        ,
        .rx_byte_count (rx_byte_count)
`endif
    );

    always #5 clock_480 = ~clock_480;

    int checks = 0;
    int passed = 0;

    // Line-level model state for the encoder side.
    logic tb_line = 1'b0;
    int   tb_ones = 0;

    // Observation log, sampled on the falling edge.
    logic [7:0] bytes_seen[$];
    int         valid_cyc[$];
    int         eop_cnt = 0;
    int         err_cnt = 0;
    int         bad_cnt = 0;
    int         active_seen = 0;
    int         cyc = 0;

    always @(posedge clock_480) cyc++;

    always @(negedge clock_480) begin
        if (reset_n) begin
            if (rx_valid) begin
                bytes_seen.push_back(rx_data);
                valid_cyc.push_back(cyc);
            end
            if (rx_eop) begin
                eop_cnt++;
`ifdef USB_RX_BYTE_COUNT_EN
                eop_byte_count = rx_byte_count;
`endif
            end
            if (rx_error) err_cnt++;
            if (rx_error && !rx_eop) bad_cnt++;
            if (rx_valid && rx_eop) bad_cnt++;
            if (rx_active) active_seen++;
        end
    end

    task automatic clear_mon();
        bytes_seen.delete();
        valid_cyc.delete();
        eop_cnt = 0;
        err_cnt = 0;
        bad_cnt = 0;
        active_seen = 0;
    endtask

    // Send one decoded bit as an NRZI line level (1 = no transition).
    task automatic send_bit(input logic d);
        if (!d) tb_line = ~tb_line;
        bit_in    = tb_line;
        bit_valid = 1'b1;
        @(posedge clock_480);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b0;
            @(posedge clock_480);
            #1;
        end
    endtask

    // Data bit with transmitter-side stuffing after six 1s.
    task automatic send_data_bit(input logic d);
        send_bit(d);
        tb_ones = d ? tb_ones + 1 : 0;
        if (tb_ones == 6) begin
            send_bit(1'b0);
            tb_ones = 0;
        end
    endtask

    task automatic send_data_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_data_bit(b[i]);
    endtask

    task automatic send_sync(input int zeros);
        for (int i = 0; i < zeros; i++) send_bit(1'b0);
        send_bit(1'b1);
        tb_ones = 1;
    endtask

    // 0xFE sent raw: a 0 followed by seven 1s, the last one being the violation.
    task automatic send_eop();
        send_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        tb_ones = 0;
        idle(1);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock_480);
        #1;
        checks++; if (rx_active !== 1'b0) $display("FAIL reset_active got=%b exp=0", rx_active); else passed++;
        checks++; if (rx_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", rx_data); else passed++;
        checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", rx_valid); else passed++;
        checks++; if (rx_eop !== 1'b0) $display("FAIL reset_eop got=%b exp=0", rx_eop); else passed++;
        checks++; if (rx_error !== 1'b0) $display("FAIL reset_error got=%b exp=0", rx_error); else passed++;
        reset_n = 1'b1;
        clear_mon();
        for (int i = 0; i < 40; i++) send_bit(1'b1);
        idle(1);
        checks++; if (active_seen !== 0) $display("FAIL idle_active got=%0d exp=0", active_seen); else passed++;
        checks++; if (bytes_seen.size() !== 0) $display("FAIL idle_valid got=%0d exp=0", bytes_seen.size()); else passed++;
        checks++; if (eop_cnt !== 0) $display("FAIL idle_eop got=%0d exp=0", eop_cnt); else passed++;
    endtask

    task automatic test_nominal();
        clear_mon();
        send_sync(31);
        checks++; if (rx_active !== 1'b1) $display("FAIL nom_active_rise got=%b exp=1", rx_active); else passed++;
        send_data_byte(8'hA5);
        checks++; if (rx_valid !== 1'b1) $display("FAIL nom_valid_latency got=%b exp=1", rx_valid); else passed++;
        send_data_byte(8'h3C);
        send_eop();
        checks++; if (bytes_seen.size() !== 2) $display("FAIL nom_count got=%0d exp=2", bytes_seen.size()); else passed++;
        checks++; if (bytes_seen[0] !== 8'hA5) $display("FAIL nom_byte0 got=%h exp=a5", bytes_seen[0]); else passed++;
        checks++; if (bytes_seen[1] !== 8'h3C) $display("FAIL nom_byte1 got=%h exp=3c", bytes_seen[1]); else passed++;
        checks++; if (eop_cnt !== 1) $display("FAIL nom_eop got=%0d exp=1", eop_cnt); else passed++;
        checks++; if (err_cnt !== 0) $display("FAIL nom_error got=%0d exp=0", err_cnt); else passed++;
        checks++; if (rx_active !== 1'b0) $display("FAIL nom_active_fall got=%b exp=0", rx_active); else passed++;
        checks++; if (rx_data !== 8'h3C) $display("FAIL nom_data_hold got=%h exp=3c", rx_data); else passed++;
`ifdef USB_RX_BYTE_COUNT_EN
        checks++; if (eop_byte_count !== 11'd2) $display("FAIL nom_byte_count got=%0d exp=2", eop_byte_count); else passed++;
`endif
    endtask

    task automatic test_stuffing();
        clear_mon();
        send_sync(12);
        send_data_byte(8'hFF);
        send_data_byte(8'h01);
        send_eop();
        checks++; if (bytes_seen.size() !== 2) $display("FAIL stuff_count got=%0d exp=2", bytes_seen.size()); else passed++;
        checks++; if (bytes_seen[0] !== 8'hFF) $display("FAIL stuff_byte0 got=%h exp=ff", bytes_seen[0]); else passed++;
        checks++; if (bytes_seen[1] !== 8'h01) $display("FAIL stuff_byte1 got=%h exp=01", bytes_seen[1]); else passed++;
        checks++; if (err_cnt !== 0 || eop_cnt !== 1) $display("FAIL stuff_eop got=eop%0d/err%0d exp=eop1/err0", eop_cnt, err_cnt); else passed++;
    endtask

    task automatic test_short_sync();
        clear_mon();
        send_sync(8);
        idle(1);
        checks++; if (active_seen !== 0) $display("FAIL short_sync_active got=%0d exp=0", active_seen); else passed++;
        send_sync(12);
        checks++; if (rx_active !== 1'b1) $display("FAIL sync12_active got=%b exp=1", rx_active); else passed++;
        send_eop();
        checks++; if (rx_active !== 1'b0) $display("FAIL sync12_end got=%b exp=0", rx_active); else passed++;
    endtask

    task automatic test_bad_eop_gap();
        logic [7:0] b;
        b = 8'hE0;
        clear_mon();
        send_sync(12);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) idle(1);
            send_data_bit(b[i]);
        end
        // Three more 1s bring bit_cnt to 3 with a run of six; the fourth violates.
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        checks++; if (rx_eop !== 1'b1 || rx_error !== 1'b1) $display("FAIL bad_eop_strobe got=eop%b/err%b exp=11", rx_eop, rx_error); else passed++;
        checks++; if (rx_valid !== 1'b0) $display("FAIL bad_eop_no_valid got=%b exp=0", rx_valid); else passed++;
        idle(1);
        checks++; if (bytes_seen.size() !== 1) $display("FAIL gap_count got=%0d exp=1", bytes_seen.size()); else passed++;
        checks++; if (bytes_seen[0] !== 8'hE0) $display("FAIL gap_byte got=%h exp=e0", bytes_seen[0]); else passed++;
        checks++; if (bad_cnt !== 0) $display("FAIL bad_eop_framing got=%0d exp=0", bad_cnt); else passed++;
        tb_ones = 0;
    endtask

    task automatic test_timeout();
        clear_mon();
        send_sync(12);
        send_data_bit(1'b1);
        send_data_bit(1'b0);
        send_data_bit(1'b1);
        send_data_bit(1'b0);
        idle(15);
        checks++; if (rx_eop !== 1'b0 || rx_active !== 1'b1) $display("FAIL timeout_early got=eop%b/act%b exp=eop0/act1", rx_eop, rx_active); else passed++;
        idle(1);
        checks++; if (rx_eop !== 1'b1 || rx_error !== 1'b1) $display("FAIL timeout_strobe got=eop%b/err%b exp=11", rx_eop, rx_error); else passed++;
        checks++; if (rx_active !== 1'b0) $display("FAIL timeout_active got=%b exp=0", rx_active); else passed++;
        idle(20);
        checks++; if (eop_cnt !== 1 || err_cnt !== 1) $display("FAIL timeout_once got=eop%0d/err%0d exp=1/1", eop_cnt, err_cnt); else passed++;
        checks++; if (bytes_seen.size() !== 0) $display("FAIL timeout_valid got=%0d exp=0", bytes_seen.size()); else passed++;
`ifdef USB_RX_BYTE_COUNT_EN
        checks++; if (eop_byte_count !== 11'd0) $display("FAIL timeout_byte_count got=%0d exp=0", eop_byte_count); else passed++;
`endif
        tb_ones = 0;
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_sync(12);
        send_data_byte(8'h00);
        send_data_byte(8'h7E);
        send_data_byte(8'h00);
        send_eop();
        checks++; if (bytes_seen.size() !== 3) $display("FAIL b2b_count got=%0d exp=3", bytes_seen.size()); else passed++;
        checks++; if (bytes_seen[1] !== 8'h7E) $display("FAIL b2b_byte1 got=%h exp=7e", bytes_seen[1]); else passed++;
        checks++; if (valid_cyc[1] - valid_cyc[0] !== 9) $display("FAIL b2b_gap_stuffed got=%0d exp=9", valid_cyc[1] - valid_cyc[0]); else passed++;
        checks++; if (valid_cyc[2] - valid_cyc[1] !== 8) $display("FAIL b2b_gap_plain got=%0d exp=8", valid_cyc[2] - valid_cyc[1]); else passed++;
        checks++; if (err_cnt !== 0) $display("FAIL b2b_error got=%0d exp=0", err_cnt); else passed++;
    endtask

    task automatic test_reset_mid_packet();
        clear_mon();
        send_sync(12);
        send_data_bit(1'b1);
        send_data_bit(1'b0);
        reset_n   = 1'b0;
        bit_valid = 1'b0;
        #1;
        checks++; if (rx_active !== 1'b0) $display("FAIL midreset_active got=%b exp=0", rx_active); else passed++;
        checks++; if (rx_data !== 8'h00) $display("FAIL midreset_data got=%h exp=00", rx_data); else passed++;
        repeat (2) @(posedge clock_480);
        #1;
        reset_n = 1'b1;
        tb_line = 1'b0;
        tb_ones = 0;
        idle(20);
        checks++; if (eop_cnt !== 0) $display("FAIL midreset_eop got=%0d exp=0", eop_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stuffing();
        test_short_sync();
        test_bad_eop_gap();
        test_timeout();
        test_back_to_back();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
